// File: rtl/zcu104_reset_ctrl.sv
// Reset-request initiator: merges power-up, lock loss, debounced button and software requests,
// holds req_reset until every domain acknowledged reset entry, then reports ready once all domains have left reset.
module zcu104_reset_ctrl #(
    parameter int NUM_DOMAINS   = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int MIN_ASSERT    = 16,
    parameter int DEBOUNCE_BITS = 8,
    parameter int TIMEOUT_BITS  = 16
) (
    input  logic                   clock,
    input  logic                   areset,
    input  logic                   pll_locked,
    input  logic                   button,
    input  logic                   sw_req,
    input  logic [NUM_DOMAINS-1:0] rst_ack,
    output logic                   req_reset,
    output logic                   ready,
    output logic [3:0]             cause,
    output logic                   ack_timeout
);

    localparam int HOLD_W = (MIN_ASSERT > 1) ? $clog2(MIN_ASSERT) : 1;
    localparam logic [HOLD_W-1:0]        HOLD_MAX = HOLD_W'(MIN_ASSERT - 1);
    localparam logic [TIMEOUT_BITS-1:0]  TMR_MAX  = '1;
    localparam logic [DEBOUNCE_BITS-1:0] DEB_MAX  = '1;

    typedef enum logic [1:0] {
        S_ASSERT,
        S_WAIT_ACK,
        S_RELEASE,
        S_READY
    } state_t;

    logic [SYNC_STAGES-1:0]                  r_lock_sync;
    logic [SYNC_STAGES-1:0]                  r_btn_sync;
    logic [SYNC_STAGES-1:0][NUM_DOMAINS-1:0] r_ack_sync;
    logic                                    r_lock_d;
    logic                                    r_btn_stable;
    logic                                    r_btn_stable_d;
    logic [DEBOUNCE_BITS-1:0]                r_deb_cnt;
    logic [HOLD_W-1:0]                       r_hold;
    logic [TIMEOUT_BITS-1:0]                 r_timer;
    state_t                                  r_state;
    logic [3:0]                              r_cause;
    logic                                    r_ack_timeout;
    logic                                    r_req_reset;
    logic                                    r_ready;

    logic                   w_lock_s;
    logic                   w_btn_s;
    logic [NUM_DOMAINS-1:0] w_ack_s;
    logic                   w_lock_fall;
    logic                   w_press;
    logic [3:0]             w_trig;
    logic                   w_any_trig;
    state_t                 w_next;
    logic                   w_set_timeout;

    assign w_lock_s    = r_lock_sync[SYNC_STAGES-1];
    assign w_btn_s     = r_btn_sync[SYNC_STAGES-1];
    assign w_ack_s     = r_ack_sync[SYNC_STAGES-1];
    assign w_lock_fall = r_lock_d & ~w_lock_s;
    assign w_press     = r_btn_stable & ~r_btn_stable_d;
    assign w_trig      = {sw_req, w_press, w_lock_fall, 1'b0};
    assign w_any_trig  = |w_trig;

    always_ff @(posedge clock) begin
        if (areset) begin
            r_lock_sync <= '0;
            r_btn_sync  <= '0;
            r_ack_sync  <= '0;
            r_lock_d    <= 1'b0;
        end else begin
            r_lock_sync[0] <= pll_locked;
            r_btn_sync[0]  <= button;
            r_ack_sync[0]  <= rst_ack;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_lock_sync[i] <= r_lock_sync[i-1];
                r_btn_sync[i]  <= r_btn_sync[i-1];
                r_ack_sync[i]  <= r_ack_sync[i-1];
            end
            r_lock_d <= w_lock_s;
        end
    end

    // Debounce: the synced button must disagree with btn_stable for 2^DEBOUNCE_BITS straight cycles.
    always_ff @(posedge clock) begin
        if (areset) begin
            r_btn_stable   <= 1'b0;
            r_btn_stable_d <= 1'b0;
            r_deb_cnt      <= '0;
        end else begin
            r_btn_stable_d <= r_btn_stable;
            if (w_btn_s == r_btn_stable) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_MAX) begin
                r_btn_stable <= ~r_btn_stable;
                r_deb_cnt    <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_set_timeout = 1'b0;
        case (r_state)
            S_ASSERT: begin
                if (r_hold == HOLD_MAX && w_lock_s && !r_btn_stable) w_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (&w_ack_s) begin
                    w_next = S_RELEASE;
                end else if (r_timer == TMR_MAX) begin
                    w_set_timeout = 1'b1;
                    w_next        = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (~|w_ack_s) begin
                    w_next = S_READY;
                end else if (r_timer == TMR_MAX) begin
                    w_set_timeout = 1'b1;
                    w_next        = S_READY;
                end
            end
            S_READY: begin
                w_next = S_READY;
            end
            default: w_next = S_ASSERT;
        endcase
        // A new request overrides whatever exit the current state was about to take.
        if (w_any_trig) begin
            w_next        = S_ASSERT;
            w_set_timeout = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (areset) begin
            r_state       <= S_ASSERT;
            r_hold        <= '0;
            r_timer       <= '0;
            r_cause       <= 4'b0001;
            r_ack_timeout <= 1'b0;
            r_req_reset   <= 1'b1;
            r_ready       <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_any_trig || r_state != S_ASSERT) begin
                r_hold <= '0;
            end else if (r_hold != HOLD_MAX) begin
                r_hold <= r_hold + 1'b1;
            end

            if (w_any_trig || w_next != r_state) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT_ACK || r_state == S_RELEASE) begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_any_trig) begin
                r_cause <= (r_state == S_READY) ? w_trig : (r_cause | w_trig);
            end

            if (w_set_timeout) r_ack_timeout <= 1'b1;

            r_req_reset <= (r_state == S_ASSERT) || (r_state == S_WAIT_ACK);
            r_ready     <= (r_state == S_READY);
        end
    end

    assign req_reset   = r_req_reset;
    assign ready       = r_ready;
    assign cause       = r_cause;
    assign ack_timeout = r_ack_timeout;

endmodule

// File: doc/zcu104_reset_ctrl.md
# zcu104_reset_ctrl

Reset-request initiator that drives the asynchronous `areset` input of the board reset generator and closes the loop on its per-domain reset outputs. It merges power-up, PLL lock loss, a debounced push-button and a software request into one held reset request. It releases the request only after every clock domain has acknowledged entry into reset, then reports `ready` once every domain has left reset. It runs on the always-on reference clock.

## Interface
- `NUM_DOMAINS`, 4: number of domain reset outputs fed back as acknowledges.
- `SYNC_STAGES`, 2: flop stages on every asynchronous input (`pll_locked`, `button`, `rst_ack`).
- `MIN_ASSERT`, 16: minimum cycles `req_reset` is held high per request; must be ≥ 1.
- `DEBOUNCE_BITS`, 8: `button` must be stable for 2^DEBOUNCE_BITS cycles to register.
- `TIMEOUT_BITS`, 16: the acknowledge timer limit is 2^TIMEOUT_BITS−1 cycles.
- `clock`  in  1  always-on reference clock.
- `areset`  in  1  reset, synchronous, active-high; clock `clock`.
- `pll_locked`  in  1  asynchronous; MMCM/PLL lock status.
- `button`  in  1  asynchronous; raw push-button, 1 = pressed.
- `sw_req`  in  1  synchronous one-cycle software reset request.
- `rst_ack`  in  NUM_DOMAINS  asynchronous; the domain reset outputs (1 = domain in reset).
- `req_reset`  out  1  reset request to the downstream reset generator; registered.
- `ready`  out  1  all domains out of reset; registered.
- `cause`  out  4  sticky cause: [0] power/areset, [1] lock loss, [2] button, [3] software.
- `ack_timeout`  out  1  sticky; an acknowledge phase timed out.

## Operation
- Inputs are synchronized through SYNC_STAGES flops. All synchronizer flops reset to 0.
- Button debounce:
  - A counter increments while the synced button differs from `btn_stable`, and clears when they match.
  - When the counter reaches 2^DEBOUNCE_BITS−1, `btn_stable` toggles and the counter clears.
  - A press event is a 0→1 transition of `btn_stable`.
- Trigger vector `trig` = {sw_req, press event, synced-lock 1→0 edge, 0}.
- State machine (one-hot or encoded):
  - ASSERT:
    - `req_reset`=1, `ready`=0.
    - The hold counter increments and saturates at MIN_ASSERT−1.
    - Exit to WAIT_ACK when counter == MIN_ASSERT−1 AND synced lock == 1 AND `btn_stable` == 0.
  - WAIT_ACK:
    - `req_reset`=1.
    - Timer counts up from 0.
    - All synced `rst_ack` == 1 → RELEASE.
    - Timer at limit → set `ack_timeout`, then RELEASE.
  - RELEASE:
    - `req_reset`=0.
    - Timer restarts from 0.
    - All synced `rst_ack` == 0 → READY.
    - Timer at limit → set `ack_timeout`, then READY.
  - READY:
    - `req_reset`=0, `ready`=1.
    - Remains in READY until a trigger.
- Any nonzero `trig`, in any state, forces the next state to ASSERT and clears the hold counter and timer.
  - From READY: `cause` ← `trig`.
  - From any other state: `cause` ← `cause` | `trig`.
- Trigger and exit condition in the same cycle: the trigger wins.
- `ack_timeout` is cleared only by `areset`.
- Counters use exact width (clog2 of the limit). There is no wrap: the hold counter saturates, and the timer is cleared on every state change.

## Timing
- Reset values:
  - state = ASSERT
  - `req_reset`=1, `ready`=0
  - `cause`=4'b0001, `ack_timeout`=0
  - all counters 0, `btn_stable`=0
- `areset` mid-operation returns to these values on the next edge, regardless of state.
- `sw_req` sampled high at edge n → `req_reset`=1 and `ready`=0 after edge n+1 (one-cycle latency).
- Lock loss → trigger seen SYNC_STAGES+1 edges after the input falls.
- `ready` rises one cycle after the synced acks are all 0 in RELEASE. Total ack latency adds SYNC_STAGES cycles.
- Minimum `req_reset` high time = MIN_ASSERT cycles + WAIT_ACK duration.
- Outputs change only on the rising edge of `clock`. There are no combinational paths from inputs to outputs.

## Test plan
- Power-up:
  - Stimulus: `areset` 3 cycles, locked=1, acks follow `req_reset` with 5-cycle delay.
  - Response: `req_reset` high ≥16 cycles; drops after acks are seen; `ready`=1; `cause`=0001; `ack_timeout`=0.
- Software request:
  - Stimulus: one-cycle `sw_req` in READY.
  - Response: `req_reset`=1 the next cycle; `cause`=1000; full sequence completes back to READY.
- Lock loss held:
  - Stimulus: `pll_locked` 1→0 in READY, held low 100 cycles.
  - Response: `req_reset` stays high until lock returns plus the ack phase; `cause`=0010.
- Button:
  - Stimulus: 100-cycle glitch.
  - Response: no action.
  - Stimulus: press held 300 cycles (DEBOUNCE_BITS=8).
  - Response: `cause`=0100; `req_reset` held while the button stays down.
- Timeout and merge:
  - Stimulus: acks tied 0 with TIMEOUT_BITS=4; `sw_req` pulsed during WAIT_ACK.
  - Response: `ack_timeout`=1 after 15 WAIT_ACK cycles; return to ASSERT with `cause` = prior | 1000.
- Mid-operation reset:
  - Stimulus: `areset` asserted in RELEASE.
  - Response: state ASSERT, `cause`=0001, `ack_timeout`=0 on the next edge.
